// File: rtl/game_ctrl.sv
// Space Invaders game sequencer: game state, wave count, BCD score and alien re-arm pulse.
// Optional high-score register enabled by defining GAME_CTRL_HIGH_SCORE_EN.
module game_ctrl #(
    parameter int unsigned MAX_WAVES      = 4,
    parameter int unsigned PAUSE_TICKS    = 8,
    parameter int unsigned POINTS_PER_HIT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Alien_Hit,
    input  logic        Aliens_Defeated,
    input  logic        Reached_Bottom,
    output logic [1:0]  Game_State,
    output logic        Game_Active,
    output logic        Aliens_Reset,
    output logic [3:0]  Wave,
    output logic [11:0] Score_BCD,
    output logic        Win,
    output logic        Lose,
    output logic [11:0] High_Score_BCD
);

    localparam int unsigned STATE_W = 2;
    localparam int unsigned WAVE_W  = 4;
    localparam int unsigned SCORE_W = 12;
    localparam int unsigned CNT_W   = 8;

    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_PLAY       = 2'b01;
    localparam logic [1:0] ST_WAVE_CLEAR = 2'b10;
    localparam logic [1:0] ST_OVER       = 2'b11;

    localparam logic [4:0]         PTS        = 5'(POINTS_PER_HIT);
    localparam logic [WAVE_W-1:0]  LAST_WAVE  = WAVE_W'(MAX_WAVES);
    localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_TICKS - 1);

    logic                 start_q;
    logic                 start_qq;
    logic                 start_rise;
    logic [STATE_W-1:0]   state;
    logic [STATE_W-1:0]   state_nxt;
    logic [CNT_W-1:0]     pause_cnt;
    logic [CNT_W-1:0]     pause_cnt_nxt;
    logic [WAVE_W-1:0]    wave_nxt;
    logic [SCORE_W-1:0]   score_nxt;
    logic                 win_nxt;
    logic                 lose_nxt;
    logic                 areset_nxt;

    // Saturating 3-digit BCD add of the per-hit point value
    function automatic logic [SCORE_W-1:0] bcd_add(input logic [SCORE_W-1:0] s);
        logic [4:0] d0;
        logic [4:0] d1;
        logic [4:0] d2;
        logic       c0;
        logic       c1;
        d0 = {1'b0, s[3:0]} + PTS;
        c0 = (d0 > 5'd9);
        if (c0) d0 = d0 - 5'd10;
        d1 = {1'b0, s[7:4]} + {4'b0000, c0};
        c1 = (d1 > 5'd9);
        if (c1) d1 = d1 - 5'd10;
        d2 = {1'b0, s[11:8]} + {4'b0000, c1};
        if (d2 > 5'd9) begin
            bcd_add = 12'h999;
        end else begin
            bcd_add = {d2[3:0], d1[3:0], d0[3:0]};
        end
    endfunction

    // Start is a slow asynchronous level: sample once, then edge-detect on the sampled copy
    assign start_rise = start_q & ~start_qq;
    assign Game_State = state;

    always_comb begin
        state_nxt     = state;
        pause_cnt_nxt = pause_cnt;
        wave_nxt      = Wave;
        score_nxt     = Score_BCD;
        win_nxt       = Win;
        lose_nxt      = Lose;
        areset_nxt    = 1'b0;

        if ((state == ST_PLAY) && Alien_Hit) begin
            score_nxt = bcd_add(Score_BCD);
        end

        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_nxt  = ST_PLAY;
                    score_nxt  = '0;
                    wave_nxt   = WAVE_W'(1);
                    win_nxt    = 1'b0;
                    lose_nxt   = 1'b0;
                    areset_nxt = 1'b1;
                end
            end
            ST_PLAY: begin
                if (Reached_Bottom) begin
                    state_nxt = ST_OVER;
                    lose_nxt  = 1'b1;
                end else if (Aliens_Defeated) begin
                    if (Wave == LAST_WAVE) begin
                        state_nxt = ST_OVER;
                        win_nxt   = 1'b1;
                    end else begin
                        state_nxt     = ST_WAVE_CLEAR;
                        pause_cnt_nxt = PAUSE_LOAD;
                    end
                end
            end
            ST_WAVE_CLEAR: begin
                if (pause_cnt == '0) begin
                    state_nxt  = ST_PLAY;
                    wave_nxt   = Wave + WAVE_W'(1);
                    areset_nxt = 1'b1;
                end else begin
                    pause_cnt_nxt = pause_cnt - CNT_W'(1);
                end
            end
            ST_OVER: begin
                if (!start_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            start_q      <= 1'b1;
            start_qq     <= 1'b1;
            state        <= ST_IDLE;
            pause_cnt    <= '0;
            Wave         <= '0;
            Score_BCD    <= '0;
            Win          <= 1'b0;
            Lose         <= 1'b0;
            Aliens_Reset <= 1'b0;
            Game_Active  <= 1'b0;
        end else begin
            start_q      <= Start;
            start_qq     <= start_q;
            state        <= state_nxt;
            pause_cnt    <= pause_cnt_nxt;
            Wave         <= wave_nxt;
            Score_BCD    <= score_nxt;
            Win          <= win_nxt;
            Lose         <= lose_nxt;
            Aliens_Reset <= areset_nxt;
            Game_Active  <= (state_nxt == ST_PLAY);
        end
    end

`ifdef GAME_CTRL_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;

    // Captured with the final score, including a hit landing on the game-ending cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            high_q <= '0;
        end else if ((state_nxt == ST_OVER) && (state != ST_OVER) && (score_nxt > high_q)) begin
            high_q <= score_nxt;
        end
    end

    assign High_Score_BCD = high_q;
`else
    assign High_Score_BCD = 12'h000;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: vector table for start/scoring/wave-clear, sequences for the rest.
module tb_game_ctrl;

    typedef struct packed {
        logic [1:0]  st;
        logic        active;
        logic        ar;
        logic [3:0]  wave;
        logic [11:0] score;
        logic        win;
        logic        lose;
    } obs_t;

    typedef struct {
        logic start;
        logic hit;
        logic def;
        logic bot;
        obs_t exp;
    } vec_t;

`ifdef GAME_CTRL_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset;
    logic a_start, a_hit, a_def, a_bot;
    logic b_start, b_hit, b_def, b_bot;

    logic [1:0]  a_state, b_state;
    logic        a_active, b_active, a_ar, b_ar, a_win, b_win, a_lose, b_lose;
    logic [3:0]  a_wave, b_wave;
    logic [11:0] a_score, b_score, a_hs, b_hs;
    obs_t        a_obs, b_obs;

    assign a_obs = {a_state, a_active, a_ar, a_wave, a_score, a_win, a_lose};
    assign b_obs = {b_state, b_active, b_ar, b_wave, b_score, b_win, b_lose};

    int n_cmp  = 0;
    int n_fail = 0;

    game_ctrl #(.MAX_WAVES(4), .PAUSE_TICKS(8), .POINTS_PER_HIT(1)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(a_start), .Alien_Hit(a_hit),
        .Aliens_Defeated(a_def), .Reached_Bottom(a_bot),
        .Game_State(a_state), .Game_Active(a_active), .Aliens_Reset(a_ar),
        .Wave(a_wave), .Score_BCD(a_score), .Win(a_win), .Lose(a_lose),
        .High_Score_BCD(a_hs)
    );

    game_ctrl #(.MAX_WAVES(1), .PAUSE_TICKS(8), .POINTS_PER_HIT(7)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(b_start), .Alien_Hit(b_hit),
        .Aliens_Defeated(b_def), .Reached_Bottom(b_bot),
        .Game_State(b_state), .Game_Active(b_active), .Aliens_Reset(b_ar),
        .Wave(b_wave), .Score_BCD(b_score), .Win(b_win), .Lose(b_lose),
        .High_Score_BCD(b_hs)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t mk(input logic [1:0] st, input logic ar, input logic [3:0] wave,
                                input logic [11:0] score, input logic win, input logic lose);
        mk = {st, (st == 2'b01), ar, wave, score, win, lose};
    endfunction

    function automatic vec_t mkv(input logic s, input logic h, input logic d, input logic b,
                                 input obs_t e);
        mkv.start = s;
        mkv.hit   = h;
        mkv.def   = d;
        mkv.bot   = b;
        mkv.exp   = e;
    endfunction

    function automatic logic [11:0] hs_exp(input logic [11:0] v);
        hs_exp = HS_EN ? v : 12'h000;
    endfunction

    task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".state"},  32'(act.st),     32'(exp.st));
        chk({tag, ".active"}, 32'(act.active), 32'(exp.active));
        chk({tag, ".areset"}, 32'(act.ar),     32'(exp.ar));
        chk({tag, ".wave"},   32'(act.wave),   32'(exp.wave));
        chk({tag, ".score"},  32'(act.score),  32'(exp.score));
        chk({tag, ".win"},    32'(act.win),    32'(exp.win));
        chk({tag, ".lose"},   32'(act.lose),   32'(exp.lose));
    endtask

    vec_t tbl[18];

    initial begin
        tbl[0]  = mkv(0, 0, 0, 0, mk(2'd0, 0, 4'd0, 12'h000, 0, 0));
        tbl[1]  = mkv(0, 0, 0, 0, mk(2'd0, 0, 4'd0, 12'h000, 0, 0));
        tbl[2]  = mkv(1, 0, 0, 0, mk(2'd0, 0, 4'd0, 12'h000, 0, 0));
        tbl[3]  = mkv(1, 0, 0, 0, mk(2'd1, 1, 4'd1, 12'h000, 0, 0));
        tbl[4]  = mkv(1, 1, 0, 0, mk(2'd1, 0, 4'd1, 12'h001, 0, 0));
        tbl[5]  = mkv(1, 0, 0, 0, mk(2'd1, 0, 4'd1, 12'h001, 0, 0));
        tbl[6]  = mkv(1, 1, 0, 0, mk(2'd1, 0, 4'd1, 12'h002, 0, 0));
        tbl[7]  = mkv(1, 1, 0, 0, mk(2'd1, 0, 4'd1, 12'h003, 0, 0));
        tbl[8]  = mkv(1, 1, 1, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[9]  = mkv(1, 1, 0, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[10] = mkv(1, 0, 0, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[11] = mkv(1, 1, 0, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[12] = mkv(1, 0, 0, 1, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[13] = mkv(1, 0, 0, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[14] = mkv(1, 0, 0, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[15] = mkv(1, 0, 0, 0, mk(2'd2, 0, 4'd1, 12'h004, 0, 0));
        tbl[16] = mkv(1, 0, 0, 0, mk(2'd1, 1, 4'd2, 12'h004, 0, 0));
        tbl[17] = mkv(1, 0, 0, 0, mk(2'd1, 0, 4'd2, 12'h004, 0, 0));

        Reset = 1'b1;
        a_start = 1'b1; a_hit = 1'b0; a_def = 1'b0; a_bot = 1'b0;
        b_start = 1'b0; b_hit = 1'b0; b_def = 1'b0; b_bot = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;

        // Switch held high through reset release must not start a game
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_obs($sformatf("hold%0d", i), a_obs, mk(2'd0, 0, 4'd0, 12'h000, 0, 0));
        end
        chk("hs_reset", 32'(a_hs), 32'h0);

        for (int i = 0; i < 18; i++) begin
            a_start = tbl[i].start;
            a_hit   = tbl[i].hit;
            a_def   = tbl[i].def;
            a_bot   = tbl[i].bot;
            tick();
            chk_obs($sformatf("vec%0d", i), a_obs, tbl[i].exp);
        end
        a_hit = 1'b0; a_def = 1'b0; a_bot = 1'b0;

        // Score climb to saturation
        a_hit = 1'b1;
        repeat (8) tick();
        chk("score_012", 32'(a_score), 32'h012);
        repeat (987) tick();
        chk("score_999", 32'(a_score), 32'h999);
        repeat (8) tick();
        chk("score_sat", 32'(a_score), 32'h999);
        a_hit = 1'b0;

        // Bottom outranks defeated; hit on exit cycle is not lost (already saturated here)
        a_def = 1'b1; a_bot = 1'b1;
        tick();
        chk_obs("both", a_obs, mk(2'd3, 0, 4'd2, 12'h999, 0, 1));
        chk("both.hs", 32'(a_hs), 32'(hs_exp(12'h999)));
        a_def = 1'b0; a_bot = 1'b0;
        tick(); tick();
        chk("over_hold", 32'(a_state), 32'd3);
        a_start = 1'b0;
        tick();
        chk("over_sync", 32'(a_state), 32'd3);
        tick();
        chk_obs("to_idle", a_obs, mk(2'd0, 0, 4'd2, 12'h999, 0, 1));
        a_start = 1'b1;
        tick();
        chk("restart_wait", 32'(a_state), 32'd0);
        tick();
        chk_obs("restart", a_obs, mk(2'd1, 1, 4'd1, 12'h000, 0, 0));

        // Reset mid-game clears everything with no re-arm pulse
        a_hit = 1'b1;
        tick();
        chk("pre_rst_score", 32'(a_score), 32'h001);
        Reset = 1'b1;
        tick();
        chk_obs("mid_rst", a_obs, mk(2'd0, 0, 4'd0, 12'h000, 0, 0));
        chk("mid_rst.hs", 32'(a_hs), 32'h0);
        Reset = 1'b0;
        a_hit = 1'b0;

        // High score across two games
        a_start = 1'b0;
        tick(); tick();
        a_start = 1'b1;
        tick(); tick();
        chk_obs("g1_start", a_obs, mk(2'd1, 1, 4'd1, 12'h000, 0, 0));
        a_hit = 1'b1;
        repeat (30) tick();
        a_hit = 1'b0;
        a_bot = 1'b1;
        tick();
        a_bot = 1'b0;
        chk_obs("g1_over", a_obs, mk(2'd3, 0, 4'd1, 12'h030, 0, 1));
        chk("g1.hs", 32'(a_hs), 32'(hs_exp(12'h030)));
        a_start = 1'b0;
        tick(); tick();
        chk("g1_idle", 32'(a_state), 32'd0);
        a_start = 1'b1;
        tick(); tick();
        chk_obs("g2_start", a_obs, mk(2'd1, 1, 4'd1, 12'h000, 0, 0));
        chk("g2_start.hs", 32'(a_hs), 32'(hs_exp(12'h030)));
        a_hit = 1'b1;
        repeat (20) tick();
        a_hit = 1'b0;
        a_bot = 1'b1;
        tick();
        a_bot = 1'b0;
        chk_obs("g2_over", a_obs, mk(2'd3, 0, 4'd1, 12'h020, 0, 1));
        chk("g2.hs", 32'(a_hs), 32'(hs_exp(12'h030)));
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("hs_cleared", 32'(a_hs), 32'h0);

        // Second instance: 7 points per hit, single wave
        tick(); tick();
        b_start = 1'b1;
        tick(); tick();
        chk_obs("b_start", b_obs, mk(2'd1, 1, 4'd1, 12'h000, 0, 0));
        b_hit = 1'b1;
        repeat (14) tick();
        chk("b_score_098", 32'(b_score), 32'h098);
        tick();
        chk("b_dbl_carry", 32'(b_score), 32'h105);
        b_hit = 1'b0;
        b_def = 1'b1;
        tick();
        b_def = 1'b0;
        chk_obs("b_win", b_obs, mk(2'd3, 0, 4'd1, 12'h105, 1, 0));
        chk("b_win.hs", 32'(b_hs), 32'(hs_exp(12'h105)));
        b_start = 1'b0;
        tick(); tick();
        chk_obs("b_idle", b_obs, mk(2'd0, 0, 4'd1, 12'h105, 1, 0));
        b_start = 1'b1;
        tick(); tick();
        chk_obs("b_restart", b_obs, mk(2'd1, 1, 4'd1, 12'h000, 0, 0));
        b_hit = 1'b1;
        repeat (142) tick();
        chk("b_score_994", 32'(b_score), 32'h994);
        tick();
        chk("b_sat", 32'(b_score), 32'h999);
        tick();
        chk("b_sat_hold", 32'(b_score), 32'h999);
        b_hit = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
